// File: rtl/mmu_sequencer.sv
// Matrix-multiply unit sequencer: tracks which A/B elements have been loaded,
// arms and runs a fixed-length compute, then gates result readout.
module mmu_sequencer #(
  parameter int DIM   = 2,
  parameter int IDX_W = $clog2(DIM*DIM),
  parameter int NCYC  = 3*DIM,
  localparam int CYC_W = $clog2(NCYC+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       instrn,
  output logic             mem_load_mat,
  output logic [IDX_W:0]   mem_addr,
  output logic             mmu_en,
  output logic [CYC_W-1:0] mmu_cycle,
  output logic             out_en,
  output logic [IDX_W-1:0] out_addr,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int NELEM = DIM*DIM;
  localparam int NBITS = 2*NELEM;
  localparam int BP_W  = $clog2(NBITS);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] ARM     = 3'd2;
  localparam logic [2:0] COMPUTE = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic             load_en, sel_ab, output_en, abort;
  logic [IDX_W-1:0] idx;
  logic             unused_instrn;

  assign load_en       = instrn[0];
  assign sel_ab        = instrn[1];
  assign output_en     = instrn[2];
  assign abort         = instrn[3];
  assign idx           = instrn[4 +: IDX_W];
  assign unused_instrn = ^instrn;

  logic [2:0]       state_q, state_d;
  logic [NBITS-1:0] bitmap_q, bitmap_d;
  logic [NBITS-1:0] load_bit;
  logic [BP_W-1:0]  bit_pos;

  logic             mem_load_mat_d, mmu_en_d, out_en_d, busy_d, done_d, err_d;
  logic [IDX_W:0]   mem_addr_d;
  logic [CYC_W-1:0] mmu_cycle_d;
  logic [IDX_W-1:0] out_addr_d;

  // A selects the low half of the bitmap, B the high half; indices past the
  // matrix size are written to memory but never count toward completion.
  always_comb begin
    bit_pos  = BP_W'(idx) + (sel_ab ? BP_W'(NELEM) : '0);
    load_bit = '0;
    if ({1'b0, idx} < (IDX_W+1)'(NELEM))
      load_bit = NBITS'(1) << bit_pos;
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path through the decode can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    bitmap_d       = bitmap_q;
    mem_load_mat_d = 1'b0;
    mem_addr_d     = '0;
    mmu_en_d       = 1'b0;
    mmu_cycle_d    = '0;
    out_en_d       = 1'b0;
    out_addr_d     = '0;
    done_d         = 1'b0;
    err_d          = err;

    if (abort) begin
      state_d  = IDLE;
      bitmap_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_en) begin
            mem_load_mat_d = 1'b1;
            mem_addr_d     = {sel_ab, idx};
            bitmap_d       = load_bit;
            err_d          = 1'b0;
            state_d        = LOAD;
          end
        end

        LOAD: begin
          if (load_en) begin
            mem_load_mat_d = 1'b1;
            mem_addr_d     = {sel_ab, idx};
            bitmap_d       = bitmap_q | load_bit;
            if (&(bitmap_q | load_bit))
              state_d = ARM;
          end
        end

        ARM: begin
          err_d   = err | load_en;
          state_d = COMPUTE;
        end

        // The first COMPUTE cycle still shows mmu_en low: that gives the
        // one-cycle arm gap between the final load strobe and the feed.
        COMPUTE: begin
          err_d = err | load_en;
          if (!mmu_en) begin
            mmu_en_d = 1'b1;
          end else if (mmu_cycle == CYC_W'(NCYC-1)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            mmu_en_d    = 1'b1;
            mmu_cycle_d = mmu_cycle + CYC_W'(1);
          end
        end

        DONE: begin
          if (load_en) begin
            mem_load_mat_d = 1'b1;
            mem_addr_d     = {sel_ab, idx};
            bitmap_d       = load_bit;
            err_d          = 1'b0;
            state_d        = LOAD;
          end else begin
            done_d = 1'b1;
            if (output_en) begin
              out_en_d   = 1'b1;
              out_addr_d = idx;
            end
          end
        end

        default: begin
          state_d  = IDLE;
          bitmap_d = '0;
          err_d    = 1'b0;
        end
      endcase
    end

    busy_d = (state_d == ARM) || (state_d == COMPUTE);
  end

  // NOTE: state and outputs update with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bitmap_q     <= '0;
      mem_load_mat <= 1'b0;
      mem_addr     <= '0;
      mmu_en       <= 1'b0;
      mmu_cycle    <= '0;
      out_en       <= 1'b0;
      out_addr     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitmap_q     <= bitmap_d;
      mem_load_mat <= mem_load_mat_d;
      mem_addr     <= mem_addr_d;
      mmu_en       <= mmu_en_d;
      mmu_cycle    <= mmu_cycle_d;
      out_en       <= out_en_d;
      out_addr     <= out_addr_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
    end
  end

endmodule

// File: tb/tb_mmu_sequencer.sv
// Self-checking bench for mmu_sequencer: directed scenarios plus random
// instructions, compared every cycle against a timeline-based reference model.
module tb_mmu_sequencer;

  localparam int DIM   = 2;
  localparam int IDX_W = 2;
  localparam int NCYC  = 6;
  localparam int CYC_W = 3;
  localparam int NELEM = DIM*DIM;
  localparam int NBITS = 2*NELEM;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       instrn;
  logic             mem_load_mat;
  logic [IDX_W:0]   mem_addr;
  logic             mmu_en;
  logic [CYC_W-1:0] mmu_cycle;
  logic             out_en;
  logic [IDX_W-1:0] out_addr;
  logic             busy, done, err;

  always #5 clk = ~clk;

  mmu_sequencer #(.DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .instrn(instrn),
    .mem_load_mat(mem_load_mat), .mem_addr(mem_addr),
    .mmu_en(mmu_en), .mmu_cycle(mmu_cycle),
    .out_en(out_en), .out_addr(out_addr),
    .busy(busy), .done(done), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: a session is a run of loads; the edge that fills the
  // bitmap is remembered, and everything after it is a function of its age.
  bit loaded[NBITS];
  bit session;
  int fill_edge;
  int edge_no;
  bit m_err;
  bit e_load, e_mmu_en, e_out_en, e_busy, e_done;
  int e_addr, e_cycle, e_out_addr;

  task automatic clear_expect();
    e_load = 0; e_mmu_en = 0; e_out_en = 0; e_busy = 0; e_done = 0;
    e_addr = 0; e_cycle = 0; e_out_addr = 0;
  endtask

  task automatic model_reset();
    foreach (loaded[i]) loaded[i] = 0;
    session   = 0;
    fill_edge = -1;
    m_err     = 0;
    clear_expect();
  endtask

  task automatic model_edge(input logic [7:0] ins);
    int  age, sel, idx;
    bit  ld, oe, ab, full;
    edge_no++;
    ld  = ins[0]; sel = int'(ins[1]); oe = ins[2]; ab = ins[3];
    idx = int'(ins[5:4]);
    age = (fill_edge >= 0) ? edge_no - fill_edge : -1;
    clear_expect();
    if (ab) begin
      foreach (loaded[i]) loaded[i] = 0;
      session   = 0;
      fill_edge = -1;
    end else if (age >= 1 && age <= NCYC+2) begin
      if (ld) m_err = 1;
      e_busy   = (age <= NCYC+1);
      e_mmu_en = (age >= 2 && age <= NCYC+1);
      e_cycle  = e_mmu_en ? age-2 : 0;
      e_done   = (age == NCYC+2);
    end else if (ld) begin
      if (!session || fill_edge >= 0) begin
        foreach (loaded[i]) loaded[i] = 0;
        m_err     = 0;
        fill_edge = -1;
      end
      session = 1;
      e_load  = 1;
      e_addr  = sel*NELEM + idx;
      loaded[sel*NELEM + idx] = 1;
      full = 1;
      foreach (loaded[i]) if (!loaded[i]) full = 0;
      if (full) begin
        fill_edge = edge_no;
        e_busy    = 1;
      end
    end else if (fill_edge >= 0) begin
      e_done = 1;
      if (oe) begin
        e_out_en   = 1;
        e_out_addr = idx;
      end
    end
  endtask

  task automatic compare_all();
    check($sformatf("mem_load_mat@%0d", edge_no), 32'(mem_load_mat), 32'(e_load));
    check($sformatf("mem_addr@%0d", edge_no),     32'(mem_addr),     e_addr);
    check($sformatf("mmu_en@%0d", edge_no),       32'(mmu_en),       32'(e_mmu_en));
    check($sformatf("mmu_cycle@%0d", edge_no),    32'(mmu_cycle),    e_cycle);
    check($sformatf("out_en@%0d", edge_no),       32'(out_en),       32'(e_out_en));
    check($sformatf("out_addr@%0d", edge_no),     32'(out_addr),     e_out_addr);
    check($sformatf("busy@%0d", edge_no),         32'(busy),         32'(e_busy));
    check($sformatf("done@%0d", edge_no),         32'(done),         32'(e_done));
    check($sformatf("err@%0d", edge_no),          32'(err),          32'(m_err));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_load"}, 32'(mem_load_mat), 0);
    check({tag, "_addr"}, 32'(mem_addr), 0);
    check({tag, "_mmu"},  32'(mmu_en), 0);
    check({tag, "_cyc"},  32'(mmu_cycle), 0);
    check({tag, "_oen"},  32'(out_en), 0);
    check({tag, "_oad"},  32'(out_addr), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"},  32'(err), 0);
  endtask

  // Inputs change on the falling edge; outputs are sampled one falling edge later.
  task automatic cycle(input logic [7:0] ins);
    instrn = ins;
    @(posedge clk);
    model_edge(ins);
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [7:0] mk(input bit ld, input bit sel, input bit oe,
                                    input bit ab, input int idx);
    logic [7:0] r;
    logic [31:0] iv;
    iv = idx;
    r = '0;
    r[0] = ld; r[1] = sel; r[2] = oe; r[3] = ab;
    r[4 +: IDX_W] = iv[IDX_W-1:0];
    return r;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(8'h00);
  endtask

  task automatic load_range(input int first, input int last);
    for (int i = first; i <= last; i++) cycle(mk(1, i / NELEM, 0, 0, i % NELEM));
  endtask

  task automatic wait_cycle(input int target, input string tag);
    for (int i = 0; i < 20 && !(e_mmu_en && e_cycle == target); i++) cycle(8'h00);
    check(tag, 32'(mmu_cycle), target);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && !e_done; i++) cycle(8'h00);
    check(tag, 32'(done), 1);
  endtask

  initial begin
    edge_no = 0;
    rst_n   = 1'b0;
    instrn  = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Back-to-back distinct loads, arm gap, compute, done.
    load_range(0, NBITS-1);
    idle(NCYC+4);

    // Duplicate A0 and idle gaps between loads.
    cycle(mk(1, 0, 0, 0, 0)); idle(2);
    cycle(mk(1, 0, 0, 0, 0)); idle(1);
    cycle(mk(1, 0, 0, 0, 1)); cycle(mk(1, 0, 0, 0, 2)); idle(3);
    cycle(mk(1, 0, 0, 0, 3)); cycle(mk(1, 1, 0, 0, 0)); cycle(mk(1, 1, 0, 0, 1));
    idle(2);
    cycle(mk(1, 1, 0, 0, 2)); idle(2);
    cycle(mk(1, 1, 0, 0, 3));
    idle(NCYC+4);

    // Load attempted mid-compute sets err; load in DONE clears it.
    cycle(mk(1, 0, 0, 0, 0));
    load_range(1, NBITS-1);
    wait_cycle(3, "wait_cyc3");
    cycle(mk(1, 0, 0, 0, 1));
    check("err_sticky", 32'(err), 1);
    wait_done("wait_done1");
    cycle(mk(1, 0, 0, 0, 0));
    check("err_cleared", 32'(err), 0);
    load_range(1, NBITS-1);
    wait_done("wait_done2");

    // Readout, then readout colliding with a load.
    cycle(mk(0, 0, 1, 0, 2));
    check("out_addr2", 32'(out_addr), 2);
    cycle(8'h00);
    cycle(mk(1, 1, 1, 0, 2));
    check("load_wins", 32'(out_en), 0);
    load_range(0, NBITS-1);
    wait_done("wait_done3");

    // Abort mid-compute, then a session short one element never computes.
    cycle(mk(1, 0, 0, 0, 0));
    load_range(1, NBITS-1);
    wait_cycle(2, "wait_cyc2");
    cycle(mk(1, 0, 1, 1, 1));
    check("abort_mmu", 32'(mmu_en), 0);
    load_range(0, NBITS-2);
    idle(NCYC+4);
    load_range(NBITS-1, NBITS-1);
    wait_done("wait_done4");

    // Asynchronous reset mid-compute.
    cycle(mk(1, 0, 0, 0, 0));
    load_range(1, NBITS-1);
    wait_cycle(3, "wait_cyc3b");
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    load_range(0, NBITS-2);
    idle(NCYC+4);
    load_range(NBITS-1, NBITS-1);
    wait_done("wait_done5");

    // Random instruction stream with occasional aborts.
    for (int i = 0; i < 800; i++) begin
      logic [7:0] ins;
      ins    = 8'($urandom);
      ins[3] = ($urandom_range(0, 49) == 0);
      cycle(ins);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmu_sequencer.md
MMU_SEQUENCER -- requirements
Module: mmu_sequencer

Interface
REQ-001 Param DIM, default 2, matrix dimension (A and B are DIM x DIM); legal 2..4.
REQ-002 Param IDX_W, default clog2(DIM*DIM), element-index width (derived, not overridden).
REQ-003 Param NCYC, default 3*DIM, compute cycles per matmul.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 instrn  in  8  instruction: [0] load_en, [1] sel_ab (0=A weights, 1=B inputs), [2] output_en, [3] abort, [4+IDX_W-1:4] index.
REQ-007 mem_load_mat  out  1  element write strobe to matrix memory.
REQ-008 mem_addr  out  IDX_W+1  {sel_ab, index} of written element.
REQ-009 mmu_en  out  1  MMU feed/compute enable.
REQ-010 mmu_cycle  out  clog2(NCYC+1)  compute cycle count.
REQ-011 out_en  out  1  result readout strobe.
REQ-012 out_addr  out  IDX_W  result element index.
REQ-013 busy  out  1  high in ARM or COMPUTE.
REQ-014 done  out  1  results valid.
REQ-015 err  out  1  sticky illegal-load flag.

Function
REQ-016 All outputs SHALL be registered; response appears after the rising edge sampling instrn.
REQ-017 States SHALL be IDLE, LOAD, ARM, COMPUTE, DONE.
REQ-018 Block SHALL keep a 2*DIM*DIM-bit loaded bitmap, one bit per {sel_ab,index}; duplicate loads rewrite memory but do not advance completion.
REQ-019 Accepted load (IDLE, LOAD, DONE): mem_load_mat=1, mem_addr={sel_ab,index}, bitmap bit set; else mem_load_mat=0, mem_addr=0.
REQ-020 IDLE + load_en -> LOAD; DONE + load_en -> LOAD with bitmap cleared before marking, done=0, err=0.
REQ-021 LOAD with load_en=0 SHALL hold state and bitmap (no count reset).
REQ-022 Load that makes bitmap all-ones -> ARM; ARM lasts exactly one cycle -> COMPUTE.
REQ-023 COMPUTE: mmu_en=1 with mmu_cycle 0..NCYC-1, +1 per cycle; mmu_en high exactly NCYC cycles; first mmu_en cycle is two cycles after the completing mem_load_mat cycle.
REQ-024 After mmu_cycle=NCYC-1 -> DONE: mmu_en=0, mmu_cycle=0, done=1, bitmap retained.
REQ-025 DONE + output_en (load_en=0): out_en=1, out_addr=index for one cycle; output_en outside DONE ignored, out_en=0.
REQ-026 DONE + load_en + output_en: load wins, out_en=0.
REQ-027 load_en in ARM/COMPUTE: ignored (no strobe, no bitmap change), err=1 sticky.
REQ-028 abort=1 in any state: next cycle IDLE, bitmap cleared, all outputs 0 except err retained; abort overrides every other field.
REQ-029 err SHALL clear only on reset or load accepted from IDLE/DONE.
REQ-030 Illegal state encoding SHALL recover to IDLE with outputs 0.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, clear bitmap, all outputs 0, including mid-COMPUTE.
REQ-032 First edge after rst_n release SHALL process instrn normally.

Verification (DIM=2, NCYC=6)
REQ-033 8 distinct loads A0..A3,B0..B3 back-to-back -> 8 strobes addr 0..7; one ARM cycle; mmu_en high 6 cycles, mmu_cycle 0..5; then done=1.
REQ-034 Loads A0,A0,A1,A2,A3,B0..B3 with idle gaps -> duplicate ignored for completion; COMPUTE only after B3; gaps hold bitmap.
REQ-035 load_en at mmu_cycle=3 -> no strobe, err=1, mmu_cycle continues to 5; next load in DONE clears err.
REQ-036 DONE, output_en index 2 -> out_en=1, out_addr=2 one cycle; same cycle with load_en -> out_en=0, LOAD, done=0.
REQ-037 abort at mmu_cycle=2 -> IDLE, mmu_en=0, done=0; 7 loads after abort -> no COMPUTE.
REQ-038 rst_n low mid-COMPUTE -> outputs 0 asynchronously; restart requires all 8 loads.
